// File: rtl/hazard_fwd_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch squash and
// registered ALU operand-select generation for the ID/EX boundary.
module hazard_fwd_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic [4:0] EX_Rd,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic       Branch_Taken,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Bubble,
  output logic [1:0] SelA,
  output logic [1:0] SelB,
  output logic       Stalled
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [1:0] SEL_RF     = 2'b00;
  localparam logic [1:0] SEL_EXMEM  = 2'b01;
  localparam logic [1:0] SEL_ZERO   = 2'b10;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] sela_q, sela_d;
  logic [1:0] selb_q, selb_d;
  logic       stalled_q, stalled_d;

  logic rd_nz, hz, fwd_a, fwd_b;

  assign rd_nz = (EX_Rd != 5'd0);
  assign hz    = EX_MemRead & EX_RegWrite & rd_nz &
                 ((EX_Rd == ID_Rs) | (ID_UsesRt & (EX_Rd == ID_Rt)));
  assign fwd_a = EX_RegWrite & !EX_MemRead & rd_nz & (EX_Rd == ID_Rs);
  assign fwd_b = EX_RegWrite & !EX_MemRead & rd_nz & ID_UsesRt & (EX_Rd == ID_Rt);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    unique case (state_q)
      RUN, STALL: begin
        // A taken branch squashes the ID instruction, so any pending stall is moot.
        if (Branch_Taken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end else if (state_q == STALL) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end else if (hz) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = STALL_LOAD;
          end
        end
      end
      FLUSH: begin
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
        if (Branch_Taken) begin
          cnt_d = FLUSH_LOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
    if (!Rst) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end
  end

  assign sela_d    = IDEX_Bubble ? SEL_ZERO : (fwd_a ? SEL_EXMEM : SEL_RF);
  assign selb_d    = IDEX_Bubble ? SEL_ZERO : (fwd_b ? SEL_EXMEM : SEL_RF);
  assign stalled_d = (state_d == STALL);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= RUN;
      cnt_q     <= 3'd0;
      sela_q    <= SEL_RF;
      selb_q    <= SEL_RF;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sela_q    <= sela_d;
      selb_q    <= selb_d;
      stalled_q <= stalled_d;
    end
  end

  assign SelA    = sela_q;
  assign SelB    = selb_q;
  assign Stalled = stalled_q;

endmodule
